// File: rtl/keypad_pkg.sv
// Shared types and constant tables for the keypad-to-display core.
package keypad_pkg;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StHeld
    } scan_state_e;

    // KeyMap[row][col] -> key code; '*' = 0xE, '#' = 0xF
    localparam logic [3:0] KeyMap [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Hex font, segments {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SegFont [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/disp_controller.sv
// Free-running digit multiplexer: steps the active digit every REFRESH_DIV cycles.
module disp_controller #(
    parameter int unsigned REFRESH_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] k,
    output logic [2:0] a
);

    localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);

    logic [RefW-1:0] ref_q, ref_d;
    logic [1:0]      k_q, k_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_q <= '0;
            k_q   <= 2'd0;
        end else begin
            ref_q <= ref_d;
            k_q   <= k_d;
        end
    end

    always_comb begin
        ref_d = ref_q + RefW'(1);
        k_d   = k_q;
        if (ref_q == RefLast) begin
            ref_d = '0;
            k_d   = (k_q == 2'd2) ? 2'd0 : k_q + 2'd1;
        end
    end

    assign k = k_q;
    assign a = ~(3'b001 << k_q);

endmodule

// File: rtl/disp_dec.sv
// Combinational hex-to-seven-segment font lookup.
module disp_dec
    import keypad_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    assign seg = SegFont[code];

endmodule

// File: rtl/lecture.sv
// Keypad scanner: row synchronizer, column-scan/debounce FSM and key encoder.
module lecture
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 27000,
    parameter int unsigned DEBOUNCE_CYCLES = 135000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas_raw,
    output logic [3:0] columnas,
    output logic       key_push,
    output logic [3:0] key_code
);

    localparam int unsigned SlotW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       rows_meta, rows;
    scan_state_e      state_q, state_d;
    logic [1:0]       col_q, col_d;
    logic [SlotW-1:0] slot_q, slot_d;
    logic [DebW-1:0]  cnt_q, cnt_d;
    logic [3:0]       pat_q, pat_d;
    logic [1:0]       row_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            rows_meta <= 4'hF;
            rows      <= 4'hF;
            state_q   <= StScan;
            col_q     <= 2'd0;
            slot_q    <= '0;
            cnt_q     <= '0;
            pat_q     <= 4'hF;
        end else begin
            rows_meta <= filas_raw;
            rows      <= rows_meta;
            state_q   <= state_d;
            col_q     <= col_d;
            slot_q    <= slot_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
        end
    end

    // Lowest-index low row wins when several rows are pulled down
    always_comb begin
        row_sel = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!pat_q[i]) row_sel = 2'(i);
        end
    end

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        slot_d   = slot_q;
        cnt_d    = cnt_q;
        pat_d    = pat_q;
        key_push = 1'b0;
        unique case (state_q)
            StScan: begin
                if (slot_q == SlotLast) begin
                    slot_d = '0;
                    if (rows != 4'hF) begin
                        pat_d   = rows;
                        cnt_d   = '0;
                        state_d = StDebounce;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    slot_d = slot_q + SlotW'(1);
                end
            end
            StDebounce: begin
                if (rows != pat_q) begin
                    slot_d  = '0;
                    state_d = StScan;
                end else if (cnt_q == DebLast) begin
                    key_push = 1'b1;
                    cnt_d    = '0;
                    state_d  = StHeld;
                end else begin
                    cnt_d = cnt_q + DebW'(1);
                end
            end
            StHeld: begin
                if (rows != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    cnt_d   = '0;
                    slot_d  = '0;
                    col_d   = col_q + 2'd1;
                    state_d = StScan;
                end else begin
                    cnt_d = cnt_q + DebW'(1);
                end
            end
            default: state_d = StScan;
        endcase
    end

    assign key_code = KeyMap[row_sel][col_q];
    assign columnas = ~(4'b0001 << col_q);

endmodule

// File: rtl/keypad_display_core.sv
// Keypad-to-display core: scanner, three-key history and multiplexed 3-digit display.
module keypad_display_core
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 27000,
    parameter int unsigned DEBOUNCE_CYCLES = 135000,
    parameter int unsigned REFRESH_DIV     = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] filas_raw,
    output logic [3:0] columnas,
    output logic [6:0] d,
    output logic [2:0] a
);

    logic            key_push;
    logic [3:0]      key_code;
    logic [1:0]      k;
    logic [2:0][3:0] dig_q;
    logic [2:0]      valid_q;
    logic [6:0]      seg;

    lecture #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_lecture (
        .clk       (clk),
        .rst       (rst),
        .filas_raw (filas_raw),
        .columnas  (columnas),
        .key_push  (key_push),
        .key_code  (key_code)
    );

    disp_controller #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_disp_controller (
        .clk (clk),
        .rst (rst),
        .k   (k),
        .a   (a)
    );

    // Newest key enters slot 0; valid bits shift alongside the codes
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_q   <= '0;
            valid_q <= '0;
        end else if (key_push) begin
            dig_q   <= {dig_q[1:0], key_code};
            valid_q <= {valid_q[1:0], 1'b1};
        end
    end

    disp_dec u_disp_dec (
        .code (dig_q[k]),
        .seg  (seg)
    );

    assign d = valid_q[k] ? seg : 7'h00;

endmodule

// File: tb/tb_keypad_display_core.sv
// Randomized self-checking bench: physical keypad model plus a key-history reference.
module tb_keypad_display_core;

    localparam int unsigned ScanDiv   = 4;
    localparam int unsigned DebCycles = 8;
    localparam int unsigned RefDiv    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] filas_raw;
    logic [3:0] columnas;
    logic [6:0] d;
    logic [2:0] a;

    keypad_display_core #(
        .SCAN_DIV        (ScanDiv),
        .DEBOUNCE_CYCLES (DebCycles),
        .REFRESH_DIV     (RefDiv)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .filas_raw (filas_raw),
        .columnas  (columnas),
        .d         (d),
        .a         (a)
    );

    always #5 clk = ~clk;

    // Closed switch at (r,c) pulls row r low while column c is driven low
    logic [15:0] pressed;
    always_comb begin
        filas_raw = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && (columnas[c] === 1'b0)) filas_raw[r] = 1'b0;
            end
        end
    end

    int cyc;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] hist[$];

    logic [6:0] exp_font [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [3:0] ref_code(input int r, input int c);
        string legend = "123A456B789C*0#D";
        byte   ch;
        ch = legend[r*4+c];
        if (ch >= "0" && ch <= "9") return 4'(ch - "0");
        if (ch >= "A" && ch <= "D") return 4'(ch - "A" + 10);
        if (ch == "*") return 4'hE;
        return 4'hF;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_push(input logic [3:0] code);
        hist.push_front(code);
        if (hist.size() > 3) void'(hist.pop_back());
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        tick(n);
        rst = 1'b0;
        hist.delete();
    endtask

    task automatic check_display(input string tag);
        logic [2:0] exp_a;
        logic [6:0] exp_d;
        for (int i = 0; i < 3 * int'(RefDiv); i++) begin
            int k;
            k = (cyc / int'(RefDiv)) % 3;
            exp_a = ~(3'b001 << k);
            exp_d = 7'h00;
            if (k < hist.size()) exp_d = exp_font[hist[k]];
            check({tag, "/a"}, a, exp_a);
            check({tag, "/d"}, d, exp_d);
            tick(1);
        end
    endtask

    task automatic press(input int r, input int c, input int hold, input int gap);
        pressed[r*4+c] = 1'b1;
        tick(hold);
        pressed = '0;
        tick(gap);
        model_push(ref_code(r, c));
    endtask

    task automatic wait_col(input string tag, input logic [3:0] want, input int limit);
        int n = 0;
        while (columnas !== want && n < limit) begin
            tick(1);
            n++;
        end
        check(tag, columnas, want);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_col;
        logic [2:0] exp_a;
        rst     = 1'b1;
        pressed = '0;

        // Reset values and idle rotation
        do_reset(2);
        check("rst/d", d, 7'h00);
        for (int n = 0; n < 24; n++) begin
            exp_col = ~(4'b0001 << ((cyc / int'(ScanDiv)) % 4));
            exp_a   = ~(3'b001 << ((cyc / int'(RefDiv)) % 3));
            check("idle/columnas", columnas, exp_col);
            check("idle/a", a, exp_a);
            tick(1);
        end

        // Single key '6'
        press(1, 2, 40, 20);
        check_display("single");

        // Three keys then a fourth shifting the history
        press(0, 0, 40, 20);
        press(1, 1, 40, 20);
        press(3, 2, 40, 20);
        check_display("three");
        press(3, 1, 40, 20);
        check_display("fourth");

        // Two rows low in the same column: lower row index wins ('5' over '8')
        pressed[1*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        tick(40);
        pressed = '0;
        tick(20);
        model_push(ref_code(1, 1));
        check_display("multirow");

        // Bounce: too short to ever debounce, history unchanged, scan keeps rotating
        for (int i = 0; i < 10; i++) begin
            pressed[0*4+3] = ~pressed[0*4+3];
            tick(3);
        end
        pressed = '0;
        tick(20);
        check_display("bounce");
        wait_col("bounce/rot0111", 4'b0111, 20);
        wait_col("bounce/rot1110", 4'b1110, 20);

        // Held 'D': one push, column frozen until the release debounce completes
        pressed[3*4+3] = 1'b1;
        tick(60);
        for (int i = 0; i < 14; i++) begin
            check("held/columnas", columnas, 4'b0111);
            tick(10);
        end
        pressed = '0;
        tick(9);
        check("held/release_hold", columnas, 4'b0111);
        tick(1);
        check("held/release_step", columnas, 4'b1110);
        tick(10);
        model_push(ref_code(3, 3));
        check_display("held");

        // Randomized key sequence
        for (int i = 0; i < 10; i++) begin
            int idx;
            idx = int'($urandom_range(0, 15));
            press(idx / 4, idx % 4, int'($urandom_range(40, 70)), int'($urandom_range(15, 30)));
            check_display("random");
        end

        // Reset while a key is held
        pressed[2*4+0] = 1'b1;
        tick(40);
        do_reset(1);
        pressed = '0;
        check("midrst/columnas", columnas, 4'b1110);
        check("midrst/a", a, 3'b110);
        check("midrst/d", d, 7'h00);
        check_display("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
